// File: rtl/seg7_scroll_ctrl.sv
// seg7_scroll_ctrl: prescaled message scroller for the seg7 index; SCROLL_BLINK_EN flashes the last char during the gap
module seg7_scroll_ctrl #(
   parameter int PRESCALE_W = 24,
   parameter int DEFAULT_DIV = 10000000,
   parameter int MSG_LEN = 16,
   parameter int GAP_STEPS = 2
) (
   input logic clk,
   input logic rst,
   input logic en,
   input logic pause,
   input logic dir,
   input logic step,
   input logic div_load,
   input logic [PRESCALE_W-1:0] div_val,
   output logic [3:0] counter,
   output logic blank,
   output logic wrap,
   output logic [1:0] state
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, GAP = 2'b11} st_t;
   localparam logic [3:0] LAST = 4'(MSG_LEN - 1);
   localparam int GW = GAP_STEPS > 1 ? $clog2(GAP_STEPS) : 1;
   st_t st, saved, rs, n_rs;
   logic [PRESCALE_W-1:0] psc, dv;
   logic [GW-1:0] gcnt, n_gcnt;
   logic [3:0] start, n_cnt;
   logic active, tick, adv, at_last, gap_exit, n_blank, n_wrap;
   assign state = st;
   // rs is the state whose rules an advance follows; in PAUSE that is the saved one
   always_comb begin
      active = (st == RUN || st == GAP) && en && !pause;
      tick = active && psc == dv - 1'b1 && !div_load;
      adv = tick || (st == PAUSE && en && pause && step);
      rs = st == PAUSE ? saved : st;
      start = dir ? LAST : 4'd0;
      at_last = counter == (dir ? 4'd0 : LAST);
      gap_exit = gcnt == GW'(GAP_STEPS - 1);
      n_rs = rs;
      n_cnt = counter;
      n_blank = blank;
      n_gcnt = gcnt;
      n_wrap = 1'b0;
      if (rs == GAP) begin
         n_rs = gap_exit ? RUN : GAP;
         n_cnt = gap_exit ? start : counter;
         n_gcnt = gap_exit ? '0 : gcnt + 1'b1;
`ifdef SCROLL_BLINK_EN
         n_blank = gap_exit ? 1'b0 : ~blank;
`else
         n_blank = !gap_exit;
`endif
      end else begin
         n_wrap = at_last;
         n_cnt = !at_last ? (dir ? counter - 4'd1 : counter + 4'd1) : (GAP_STEPS > 0 ? counter : start);
         n_rs = at_last && GAP_STEPS > 0 ? GAP : RUN;
         n_blank = at_last && GAP_STEPS > 0;
         n_gcnt = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= IDLE;
         saved <= RUN;
         counter <= 4'd0;
         blank <= 1'b1;
         wrap <= 1'b0;
         psc <= '0;
         dv <= PRESCALE_W'(DEFAULT_DIV);
         gcnt <= '0;
      end else begin
         wrap <= 1'b0;
         dv <= div_load ? (div_val == '0 ? PRESCALE_W'(1) : div_val) : dv;
         // holding the prescaler on the pause edge keeps the pending tick for resume
         psc <= (div_load || !en || st == IDLE) ? '0 : active ? (psc == dv - 1'b1 ? '0 : psc + 1'b1) : psc;
         if (!en) begin
            st <= IDLE;
            counter <= 4'd0;
            blank <= 1'b1;
            gcnt <= '0;
         end else if (st == IDLE) begin
            st <= RUN;
            counter <= start;
            blank <= 1'b0;
         end else if (st != PAUSE && pause) begin
            saved <= st;
            st <= PAUSE;
         end else if (st == PAUSE && !pause) begin
            st <= saved;
         end else if (adv) begin
            counter <= n_cnt;
            blank <= n_blank;
            gcnt <= n_gcnt;
            wrap <= n_wrap;
            if (st == PAUSE) saved <= n_rs;
            else st <= n_rs;
         end
      end
   end
endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// tb_seg7_scroll_ctrl: table plus scripted sequences with a scoreboard for seg7_scroll_ctrl
module tb_seg7_scroll_ctrl;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, pause = 1'b0, dir = 1'b0, step = 1'b0, div_load = 1'b0;
   logic [23:0] div_val = '0;
   logic [3:0] counter;
   logic blank, wrap;
   logic [1:0] state;
   int checks = 0, errors = 0;
   localparam integer IDLE = 0, RUN = 1, PAUSE = 2, GAP = 3;
`ifdef SCROLL_BLINK_EN
   localparam integer BLINK = 1;
`else
   localparam integer BLINK = 0;
`endif
   typedef struct {integer c, b, w, s;} exp_t;
   typedef struct {integer en, pause, dir, step, ld, dv, n, c, b, w, s;} vec_t;
   exp_t sb[$];
   vec_t tbl[28];
   seg7_scroll_ctrl #(.PRESCALE_W(24), .DEFAULT_DIV(20), .MSG_LEN(16), .GAP_STEPS(2)) dut (
      .clk(clk), .rst(rst), .en(en), .pause(pause), .dir(dir), .step(step),
      .div_load(div_load), .div_val(div_val), .counter(counter), .blank(blank),
      .wrap(wrap), .state(state)
   );
   always #5 clk = ~clk;
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic chk(input string nm, input int n, input integer c, input integer b, input integer w, input integer s);
      exp_t e;
      sb.push_back('{c, b, w, s});
      repeat (n) @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (counter !== e.c[3:0] || blank !== e.b[0] || wrap !== e.w[0] || state !== e.s[1:0]) begin
         errors++;
         $display("FAIL %s: got counter=%0d blank=%0b wrap=%0b state=%0d, want counter=%0d blank=%0d wrap=%0d state=%0d",
                  nm, counter, blank, wrap, state, e.c, e.b, e.w, e.s);
      end
   endtask
   task automatic run_pass(input logic d, input int dv);
      integer k, first, last;
      first = d ? 15 : 0;
      last = d ? 0 : 15;
      en = 1'b0;
      chk("pass_idle", 1, 0, 1, 0, IDLE);
      div_load = 1'b1;
      div_val = dv[23:0];
      chk("pass_load", 1, 0, 1, 0, IDLE);
      div_load = 1'b0;
      en = 1'b1;
      dir = d;
      chk("pass_start", 1, first, 0, 0, RUN);
      for (int i = 1; i <= 18 * dv; i++) begin
         k = i / dv;
         if (k < 16) chk("pass_run", 1, d ? 15 - k : k, 0, 0, RUN);
         else if (k < 18) chk("pass_gap", 1, last, BLINK != 0 ? ((k == 16) ? 1 : 0) : 1, (i == 16 * dv) ? 1 : 0, GAP);
         else chk("pass_restart", 1, first, 0, 0, RUN);
      end
   endtask
   initial begin
      tbl[0]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, IDLE};
      tbl[1]  = '{0, 0, 0, 0, 1, 4, 1, 0, 1, 0, IDLE};
      tbl[2]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, RUN};
      tbl[3]  = '{1, 0, 0, 0, 0, 0, 22, 5, 0, 0, RUN};
      tbl[4]  = '{1, 1, 0, 0, 0, 0, 1, 5, 0, 0, PAUSE};
      tbl[5]  = '{1, 1, 0, 0, 0, 0, 20, 5, 0, 0, PAUSE};
      tbl[6]  = '{1, 1, 0, 1, 0, 0, 1, 6, 0, 0, PAUSE};
      tbl[7]  = '{1, 1, 0, 0, 0, 0, 1, 6, 0, 0, PAUSE};
      tbl[8]  = '{1, 1, 0, 1, 0, 0, 1, 7, 0, 0, PAUSE};
      tbl[9]  = '{1, 1, 0, 1, 0, 0, 1, 8, 0, 0, PAUSE};
      tbl[10] = '{1, 0, 0, 0, 0, 0, 1, 8, 0, 0, RUN};
      tbl[11] = '{1, 0, 0, 0, 0, 0, 1, 8, 0, 0, RUN};
      tbl[12] = '{1, 0, 0, 0, 0, 0, 1, 9, 0, 0, RUN};
      tbl[13] = '{1, 0, 0, 1, 0, 0, 1, 9, 0, 0, RUN};
      tbl[14] = '{1, 0, 0, 0, 0, 0, 2, 9, 0, 0, RUN};
      tbl[15] = '{1, 0, 0, 0, 1, 0, 1, 9, 0, 0, RUN};
      tbl[16] = '{1, 0, 0, 0, 0, 0, 1, 10, 0, 0, RUN};
      tbl[17] = '{1, 0, 0, 0, 0, 0, 1, 11, 0, 0, RUN};
      tbl[18] = '{1, 0, 0, 0, 0, 0, 4, 15, 0, 0, RUN};
      tbl[19] = '{1, 0, 0, 0, 0, 0, 1, 15, 1, 1, GAP};
      tbl[20] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, IDLE};
      tbl[21] = '{1, 0, 1, 0, 0, 0, 1, 15, 0, 0, RUN};
      tbl[22] = '{1, 1, 1, 0, 0, 0, 1, 15, 0, 0, PAUSE};
      tbl[23] = '{1, 1, 1, 1, 0, 0, 1, 14, 0, 0, PAUSE};
      tbl[24] = '{0, 1, 1, 1, 0, 0, 1, 0, 1, 0, IDLE};
      tbl[25] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, RUN};
      tbl[26] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, PAUSE};
      tbl[27] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, IDLE};
      chk("reset", 2, 0, 1, 0, IDLE);
      rst = 1'b0;
      run_pass(1'b0, 4);
      run_pass(1'b1, 1);
      for (int i = 0; i < 28; i++) begin
         en = tbl[i].en[0];
         pause = tbl[i].pause[0];
         dir = tbl[i].dir[0];
         step = tbl[i].step[0];
         div_load = tbl[i].ld[0];
         div_val = tbl[i].dv[23:0];
         chk($sformatf("vec%0d", i), tbl[i].n, tbl[i].c, tbl[i].b, tbl[i].w, tbl[i].s);
      end
      step = 1'b0;
      div_load = 1'b0;
      en = 1'b1;
      chk("pre_rst", 3, 2, 0, 0, RUN);
      rst = 1'b1;
      chk("rst_mid", 1, 0, 1, 0, IDLE);
      rst = 1'b0;
      chk("rst_run", 1, 0, 0, 0, RUN);
      chk("rst_div_hold", 19, 0, 0, 0, RUN);
      chk("rst_div_tick", 1, 1, 0, 0, RUN);
      run_pass(1'b0, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
